// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer for the 5-stage RV32I core: load-use stall, EX forwarding,
// redirect flush and DMEM wait/timeout freeze. Optional perf counters under HAZARD_PERF_EN.
module hazard_ctrl #(
    parameter int AW           = 5,
    parameter int DMEM_TIMEOUT = 255,
    parameter int TO_W         = 8,
    parameter int CNT_W        = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [AW-1:0]    i_id_rs1_addr,
    input  logic             i_id_rs1_used,
    input  logic [AW-1:0]    i_id_rs2_addr,
    input  logic             i_id_rs2_used,
    input  logic [AW-1:0]    i_ex_rs1_addr,
    input  logic [AW-1:0]    i_ex_rs2_addr,
    input  logic [AW-1:0]    i_ex_rd_addr,
    input  logic             i_ex_rd_wren,
    input  logic             i_ex_is_load,
    input  logic             i_ex_pc_sel,
    input  logic [AW-1:0]    i_mem_rd_addr,
    input  logic             i_mem_rd_wren,
    input  logic [AW-1:0]    i_wb_rd_addr,
    input  logic             i_wb_rd_wren,
    input  logic             i_dmem_req,
    input  logic             i_dmem_ack,
    output logic             o_stall_pc,
    output logic             o_stall_ifid,
    output logic             o_stall_idex,
    output logic             o_stall_exmem,
    output logic             o_flush_ifid,
    output logic             o_flush_idex,
    output logic             o_bubble_memwb,
    output logic [1:0]       o_fwd_a_sel,
    output logic [1:0]       o_fwd_b_sel,
    output logic             o_dmem_err,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_WAIT  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;

    logic load_use;
    logic hold_all;
    logic run_rules;

    assign load_use = i_ex_is_load && i_ex_rd_wren && (i_ex_rd_addr != '0) &&
                      ((i_id_rs1_used && (i_id_rs1_addr == i_ex_rd_addr)) ||
                       (i_id_rs2_used && (i_id_rs2_addr == i_ex_rd_addr)));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= S_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // The request cycle itself already freezes the pipe; the counter measures the WAIT
    // cycles after it, so FAULT follows DMEM_TIMEOUT WAIT cycles without an ack.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        hold_all   = 1'b0;
        run_rules  = 1'b0;
        case (state_q)
            S_RUN: begin
                if (i_dmem_req && !i_dmem_ack) begin
                    hold_all   = 1'b1;
                    state_d    = S_WAIT;
                    wait_cnt_d = '0;
                end else begin
                    run_rules = 1'b1;
                end
            end
            S_WAIT: begin
                if (i_dmem_ack) begin
                    run_rules  = 1'b1;
                    state_d    = S_RUN;
                    wait_cnt_d = '0;
                end else begin
                    hold_all = 1'b1;
                    if (wait_cnt_q == TO_W'(DMEM_TIMEOUT - 1)) begin
                        state_d = S_FAULT;
                    end else begin
                        wait_cnt_d = wait_cnt_q + TO_W'(1);
                    end
                end
            end
            S_FAULT: begin
                hold_all = 1'b1;
            end
            default: begin
                state_d    = S_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        o_stall_pc     = 1'b0;
        o_stall_ifid   = 1'b0;
        o_stall_idex   = 1'b0;
        o_stall_exmem  = 1'b0;
        o_flush_ifid   = 1'b0;
        o_flush_idex   = 1'b0;
        o_bubble_memwb = 1'b0;
        o_fwd_a_sel    = 2'b00;
        o_fwd_b_sel    = 2'b00;
        if (!i_reset) begin
            if (hold_all) begin
                o_stall_pc     = 1'b1;
                o_stall_ifid   = 1'b1;
                o_stall_idex   = 1'b1;
                o_stall_exmem  = 1'b1;
                o_bubble_memwb = 1'b1;
            end else if (run_rules) begin
                if (load_use) begin
                    o_stall_pc   = 1'b1;
                    o_stall_ifid = 1'b1;
                    o_flush_idex = 1'b1;
                end else if (i_ex_pc_sel) begin
                    o_flush_ifid = 1'b1;
                    o_flush_idex = 1'b1;
                end
            end
            // MEM result is younger than WB data, so it wins when both match.
            if (i_mem_rd_wren && (i_mem_rd_addr != '0) && (i_mem_rd_addr == i_ex_rs1_addr))
                o_fwd_a_sel = 2'b01;
            else if (i_wb_rd_wren && (i_wb_rd_addr != '0) && (i_wb_rd_addr == i_ex_rs1_addr))
                o_fwd_a_sel = 2'b10;
            if (i_mem_rd_wren && (i_mem_rd_addr != '0) && (i_mem_rd_addr == i_ex_rs2_addr))
                o_fwd_b_sel = 2'b01;
            else if (i_wb_rd_wren && (i_wb_rd_addr != '0) && (i_wb_rd_addr == i_ex_rs2_addr))
                o_fwd_b_sel = 2'b10;
        end
    end

    assign o_dmem_err = (state_q == S_FAULT);

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (o_stall_pc && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (o_flush_ifid && i_ex_pc_sel && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;
`else
    assign o_stall_cnt = '0;
    assign o_flush_cnt = '0;
`endif

endmodule
